fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream_if.sv | 12 +
 rtl/fifo_rd_stream.sv | 134 +++++++++++++
 tb/tb_fifo_rd_stream.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying words drained from the async FIFO read side.
// master drives the words and slave applies backpressure.
interface fifo_rd_stream_if #(
    parameter int dw = 16
) ();
    logic          m_valid;
    logic          m_ready;
    logic [dw-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain stage: pops rinc/rempty/rdata into a small circular buffer and presents a
// registered valid/ready stream. FIFO_RD_STREAM_CNT_EN adds the m_cnt delivered-word counter.
module fifo_rd_stream #(
    parameter int dw        = 16,
    parameter int rd_lat    = 1,
    parameter int buf_depth = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rempty,
    input  logic [dw-1:0] rdata,
    output logic          rinc,
    fifo_rd_stream_if.master m
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [31:0]   m_cnt
`endif
);

    localparam int pw  = (buf_depth > 1) ? $clog2(buf_depth) : 1;
    localparam int cw  = $clog2(buf_depth + 1);
    localparam int cw1 = cw + 1;

    logic [dw-1:0] mem_q [buf_depth];
    logic [pw-1:0] wr_ptr_q;
    logic [pw-1:0] rd_ptr_q;
    logic [pw-1:0] rd_ptr_nxt;
    logic [cw-1:0] occ_q;
    logic [cw-1:0] occ_d;
    logic          valid_q;
    logic [dw-1:0] data_q;
    logic [dw-1:0] data_d;
    logic          lat_vld_q;
    logic          cap;
    logic          pop;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [pw-1:0] ptr_inc(input logic [pw-1:0] p);
        return (p == pw'(buf_depth - 1)) ? '0 : p + pw'(1);
    endfunction

    if (rd_lat == 1) begin : g_lat1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lat_vld_q <= 1'b0;
            end else begin
                lat_vld_q <= rinc;
            end
        end
        assign cap = lat_vld_q;
    end else begin : g_lat0
        assign lat_vld_q = 1'b0;
        assign cap       = rinc;
    end

    // In-flight reads reserve a slot, so the buffer can never overflow.
    assign rinc = !rempty &&
                  (({1'b0, occ_q} + {{cw{1'b0}}, lat_vld_q}) < cw1'(buf_depth));

    assign pop        = valid_q && m.m_ready;
    assign rd_ptr_nxt = ptr_inc(rd_ptr_q);

    always_comb begin
        occ_d = occ_q;
        if (cap && !pop) begin
            occ_d = occ_q + cw'(1);
        end else if (!cap && pop) begin
            occ_d = occ_q - cw'(1);
        end
    end

    // The head register follows the next entry on pop; with one entry left
    // the next entry is whatever is being captured on this edge.
    always_comb begin
        data_d = data_q;
        if (pop) begin
            if (occ_q == cw'(1)) begin
                if (cap) begin
                    data_d = rdata;
                end
            end else begin
                data_d = mem_q[rd_ptr_nxt];
            end
        end else if (cap && (occ_q == '0)) begin
            data_d = rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            if (cap) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            occ_q   <= occ_d;
            valid_q <= (occ_d != '0);
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            mem_q[wr_ptr_q] <= rdata;
        end
    end

    assign m.m_valid = valid_q;
    assign m.m_data  = data_q;

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign m_cnt = cnt_q;
`endif

    occ_bound: assert property (@(posedge clk) disable iff (!rst_n) occ_q <= cw'(buf_depth));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO (registered read) plus an in-order word scoreboard.
// Define FIFO_RD_STREAM_CNT_EN to also exercise the delivered-word counter.
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rempty;
    logic        rinc;
    logic [15:0] rdata;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [31:0] m_cnt;
`endif

    fifo_rd_stream_if #(.dw(16)) s ();

    fifo_rd_stream #(.dw(16), .rd_lat(1), .buf_depth(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rempty (rempty),
        .rdata  (rdata),
        .rinc   (rinc),
        .m      (s)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .m_cnt  (m_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // FIFO model: one-cycle registered read; reset empties it.
    logic [15:0] fifo_mem [64];
    int          fifo_wp = 0;
    int          fifo_rp = 0;
    logic        hold_empty = 1'b0;
    logic [15:0] exp_q [$];

    assign rempty = (fifo_rp == fifo_wp) || hold_empty;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_rp <= fifo_wp;
            rdata   <= 16'h0;
        end else if (rinc) begin
            rdata   <= fifo_mem[fifo_rp % 64];
            fifo_rp <= fifo_rp + 1;
        end
    end

    task automatic push_word(input logic [15:0] w);
        fifo_mem[fifo_wp % 64] = w;
        fifo_wp++;
        exp_q.push_back(w);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (rinc !== 1'b0) $display("FAIL reset_rinc got=%b want=0", rinc); else passes++;
        checks++; if (s.m_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", s.m_valid);
        else passes++;
        checks++; if (s.m_data !== 16'h0) $display("FAIL reset_data got=%h want=0000", s.m_data);
        else passes++;
`ifdef FIFO_RD_STREAM_CNT_EN
        checks++; if (m_cnt !== 32'h0) $display("FAIL reset_cnt got=%0d want=0", m_cnt);
        else passes++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (s.m_valid !== 1'b0 || rinc !== 1'b0)
            $display("FAIL idle_after_reset valid=%b rinc=%b want=0/0", s.m_valid, rinc);
        else passes++;
    endtask

    task automatic test_stream();
        int first_rinc = -1, last_rinc = -1, n_rinc = 0, first_valid = -1, n_got = 0, bubbles = 0;
        logic [15:0] w;
        for (int c = 0; c < 40 && n_got < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                s.m_ready = 1'b1;
                for (int i = 1; i <= 8; i++) push_word(16'(i));
            end
            #1;
            if (rinc) begin
                if (first_rinc < 0) first_rinc = c;
                last_rinc = c;
                n_rinc++;
            end
            if (s.m_valid) begin
                if (first_valid < 0) first_valid = c;
                w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++; if (s.m_data !== w)
                    $display("FAIL stream_word%0d got=%h want=%h", n_got, s.m_data, w);
                else passes++;
                n_got++;
            end else if (first_valid >= 0) begin
                bubbles++;
            end
        end
        checks++; if (n_rinc != 8) $display("FAIL stream_rinc_count got=%0d want=8", n_rinc);
        else passes++;
        checks++; if (last_rinc - first_rinc != 7)
            $display("FAIL stream_rinc_contig span=%0d want=7", last_rinc - first_rinc);
        else passes++;
        checks++; if (first_valid != first_rinc + 2)
            $display("FAIL stream_latency got=%0d want=%0d", first_valid, first_rinc + 2);
        else passes++;
        checks++; if (n_got != 8 || bubbles != 0)
            $display("FAIL stream_no_bubbles got=%0d words %0d bubbles want=8/0", n_got, bubbles);
        else passes++;
    endtask

    task automatic test_backpressure();
        int n_rinc = 0, hold_bad = 0, n_got = 0;
        logic [15:0] w;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                s.m_ready = 1'b0;
                for (int i = 1; i <= 8; i++) push_word(16'(i));
            end
            #1;
            if (rinc) n_rinc++;
            if (c >= 2 && (s.m_valid !== 1'b1 || s.m_data !== 16'h0001)) hold_bad++;
        end
        checks++; if (n_rinc != 3) $display("FAIL bp_rinc_pulses got=%0d want=3", n_rinc);
        else passes++;
        checks++; if (rinc !== 1'b0) $display("FAIL bp_rinc_held got=%b want=0", rinc);
        else passes++;
        checks++; if (hold_bad != 0) $display("FAIL bp_head_hold got=%0d bad cycles want=0", hold_bad);
        else passes++;
        for (int c = 0; c < 40 && n_got < 8; c++) begin
            @(negedge clk);
            s.m_ready = 1'b1;
            #1;
            if (s.m_valid) begin
                w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++; if (s.m_data !== w)
                    $display("FAIL bp_word%0d got=%h want=%h", n_got, s.m_data, w);
                else passes++;
                n_got++;
            end
        end
        checks++; if (n_got != 8 || exp_q.size() != 0)
            $display("FAIL bp_drain got=%0d left=%0d want=8/0", n_got, exp_q.size());
        else passes++;
    endtask

    task automatic test_toggle();
        int issued = 0, delivered = 0, stall_bad = 0, over_bad = 0;
        logic prev_stall = 1'b0;
        logic [15:0] prev_data = 16'h0;
        logic [15:0] w;
        for (int c = 0; c < 60 && delivered < 6; c++) begin
            @(negedge clk);
            if (c == 0) for (int i = 0; i < 6; i++) push_word(16'($urandom));
            s.m_ready = (c % 2 == 0);
            #1;
            if (prev_stall && (s.m_valid !== 1'b1 || s.m_data !== prev_data)) stall_bad++;
            prev_stall = s.m_valid && !s.m_ready;
            prev_data  = s.m_data;
            if (rinc) issued++;
            if (s.m_valid && s.m_ready) begin
                w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++; if (s.m_data !== w)
                    $display("FAIL toggle_word%0d got=%h want=%h", delivered, s.m_data, w);
                else passes++;
                delivered++;
            end
            if (issued - delivered > 3) over_bad++;
        end
        checks++; if (delivered != 6) $display("FAIL toggle_count got=%0d want=6", delivered);
        else passes++;
        checks++; if (stall_bad != 0) $display("FAIL toggle_stable got=%0d bad want=0", stall_bad);
        else passes++;
        checks++; if (over_bad != 0) $display("FAIL toggle_occ_bound got=%0d bad want=0", over_bad);
        else passes++;
    endtask

    task automatic test_trickle();
        int pattern_bad = 0;
        logic [15:0] w;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            s.m_ready = 1'b1;
            if (c % 4 == 0) push_word(16'($urandom));
            #1;
            if (rinc !== (c % 4 == 0) || s.m_valid !== (c % 4 == 2)) pattern_bad++;
            if (c % 4 == 2) begin
                w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++; if (s.m_data !== w)
                    $display("FAIL trickle_word%0d got=%h want=%h", c / 4, s.m_data, w);
                else passes++;
            end
        end
        checks++; if (pattern_bad != 0)
            $display("FAIL trickle_timing got=%0d bad cycles want=0", pattern_bad);
        else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL trickle_left got=%0d want=0", exp_q.size());
        else passes++;
    endtask

    task automatic test_random();
        int n_got = 0;
        logic [15:0] w;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if ($urandom_range(2, 0) == 0 && fifo_wp - fifo_rp < 48) push_word(16'($urandom));
            hold_empty = ($urandom_range(4, 0) == 0);
            s.m_ready  = $urandom_range(1, 0) == 1;
            #1;
            if (s.m_valid && s.m_ready) begin
                w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++; if (s.m_data !== w)
                    $display("FAIL random_word%0d got=%h want=%h", n_got, s.m_data, w);
                else passes++;
                n_got++;
            end
        end
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            hold_empty = 1'b0;
            s.m_ready  = 1'b1;
            #1;
            if (s.m_valid) begin
                w = exp_q.pop_front();
                checks++; if (s.m_data !== w)
                    $display("FAIL random_drain%0d got=%h want=%h", n_got, s.m_data, w);
                else passes++;
                n_got++;
            end
        end
        checks++; if (exp_q.size() != 0) $display("FAIL random_timeout left=%0d want=0", exp_q.size());
        else passes++;
        @(negedge clk);
        #1;
        checks++; if (s.m_valid !== 1'b0) $display("FAIL random_no_extra got=%b want=0", s.m_valid);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                s.m_ready = 1'b0;
                for (int i = 0; i < 4; i++) push_word(16'($urandom) | 16'h0001);
            end
            #1;
        end
        // Two words buffered, one read in flight.
        checks++; if (s.m_valid !== 1'b1) $display("FAIL rstmid_pre_valid got=%b want=1", s.m_valid);
        else passes++;
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checks++; if (s.m_valid !== 1'b0) $display("FAIL rstmid_valid got=%b want=0", s.m_valid);
        else passes++;
        checks++; if (s.m_data !== 16'h0) $display("FAIL rstmid_data got=%h want=0000", s.m_data);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        s.m_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (rinc !== 1'b0 || s.m_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) $display("FAIL rstmid_quiet got=%0d bad cycles want=0", bad);
        else passes++;
    endtask

`ifdef FIFO_RD_STREAM_CNT_EN
    task automatic test_cnt();
        int n_got = 0;
        s.m_ready = 1'b1;
        for (int c = 0; c < 60 && n_got < 10; c++) begin
            @(negedge clk);
            if (c == 0) for (int i = 0; i < 10; i++) push_word(16'($urandom));
            #1;
            if (s.m_valid) begin
                void'(exp_q.pop_front());
                n_got++;
            end
        end
        @(negedge clk);
        #1;
        checks++; if (m_cnt !== 32'd10) $display("FAIL cnt_ten got=%0d want=10", m_cnt);
        else passes++;
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.cnt_q;
        n_got = 0;
        for (int c = 0; c < 40 && n_got < 3; c++) begin
            @(negedge clk);
            if (c == 0) for (int i = 0; i < 3; i++) push_word(16'($urandom));
            #1;
            if (s.m_valid) begin
                void'(exp_q.pop_front());
                n_got++;
            end
        end
        @(negedge clk);
        #1;
        checks++; if (m_cnt !== 32'd1) $display("FAIL cnt_wrap got=%0d want=1", m_cnt);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_trickle();
        test_random();
        test_reset_mid();
`ifdef FIFO_RD_STREAM_CNT_EN
        test_cnt();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
